// File: rtl/hci_core_rr_arbiter_2x1_if.sv
// HCI core TCDM port bundle: request fields travel master->slave, and
// grant plus response fields travel slave->master.
interface hci_core_rr_arbiter_2x1_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned UW = 1
) ();

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            we_n;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [UW-1:0]   user;
    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic [UW-1:0]   r_user;

    // The side that issues requests and receives responses
    modport master (
        output req, add, we_n, be, data, user,
        input  gnt, r_valid, r_data, r_user
    );

    // The side that accepts requests and returns responses
    modport slave (
        input  req, add, we_n, be, data, user,
        output gnt, r_valid, r_data, r_user
    );

endinterface

// File: rtl/hci_core_rr_arbiter_2x1.sv
// Two-to-one round-robin arbiter for an HCI core TCDM port.
// Requests from s0/s1 are multiplexed onto m combinationally; the owner of each
// tracked transaction is queued in a small in-order FIFO so every response
// can be steered back to the requester that issued it.
module hci_core_rr_arbiter_2x1 #(
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned UW              = 1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          WRITE_RESP      = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    hci_core_rr_arbiter_2x1_if.slave  s0,
    hci_core_rr_arbiter_2x1_if.slave  s1,
    hci_core_rr_arbiter_2x1_if.master m,
    output logic                      err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = PW + 1;

    // Arbitration state and request-side signals
    logic            prio_q;
    logic            sel;
    logic [1:0]      req_vec;
    logic            any_req;
    logic            handshake;
    logic            track;

    // Muxed request fields of the selected requester
    logic [AW-1:0]   sel_add;
    logic            sel_we_n;
    logic [DW/8-1:0] sel_be;
    logic [DW-1:0]   sel_data;
    logic [UW-1:0]   sel_user;

    // Owner FIFO: one bit per outstanding tracked transaction
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       head;

    assign req_vec = {s1.req, s0.req};
    assign any_req = |req_vec;

    // Pick the priority holder when it asks, otherwise fall back to the other side
    always_comb begin
        sel = prio_q;
        if (req_vec[prio_q]) begin
            sel = prio_q;
        end else if (req_vec[~prio_q]) begin
            sel = ~prio_q;
        end
    end

    // Route the selected requester's fields onto the shared port
    always_comb begin
        sel_add  = s0.add;
        sel_we_n = s0.we_n;
        sel_be   = s0.be;
        sel_data = s0.data;
        sel_user = s0.user;
        if (sel) begin
            sel_add  = s1.add;
            sel_we_n = s1.we_n;
            sel_be   = s1.be;
            sel_data = s1.data;
            sel_user = s1.user;
        end
    end

    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Requests are held off entirely while the owner FIFO cannot take another entry
    assign m.req  = any_req & ~full;
    assign m.add  = sel_add;
    assign m.we_n = sel_we_n;
    assign m.be   = sel_be;
    assign m.data = sel_data;
    assign m.user = sel_user;

    assign handshake = m.req & m.gnt;
    assign s0.gnt    = handshake & ~sel;
    assign s1.gnt    = handshake &  sel;

    // Writes only occupy a FIFO slot when the memory side answers them
    assign track = sel_we_n | WRITE_RESP;
    assign push  = handshake & track;
    assign pop   = m.r_valid & ~empty;
    assign head  = owner_q[rd_ptr_q];

    // Responses go to the head owner; data and user are broadcast to both sides
    assign s0.r_valid = m.r_valid & ~empty & ~head;
    assign s1.r_valid = m.r_valid & ~empty &  head;
    assign s0.r_data  = m.r_data;
    assign s1.r_data  = m.r_data;
    assign s0.r_user  = m.r_user;
    assign s1.r_user  = m.r_user;

    // Hand priority to the loser after every accepted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (clear_i) begin
            prio_q <= 1'b0;
        end else if (handshake) begin
            prio_q <= ~sel;
        end
    end

    // Owner FIFO storage, pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Flag a response that arrives with nobody waiting for it; sticky until reset or clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (clear_i) begin
            err_o <= 1'b0;
        end else if (m.r_valid && empty) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hci_core_rr_arbiter_2x1.sv
// Directed bench for the two-to-one round-robin arbiter with default parameters
// (four outstanding entries, writes untracked).
module tb_hci_core_rr_arbiter_2x1;

    logic clk;
    logic rst_n;
    logic clear;
    logic err;

    int checks;
    int failures;

    hci_core_rr_arbiter_2x1_if #(.DW(32), .AW(32), .UW(1)) s0_if ();
    hci_core_rr_arbiter_2x1_if #(.DW(32), .AW(32), .UW(1)) s1_if ();
    hci_core_rr_arbiter_2x1_if #(.DW(32), .AW(32), .UW(1)) m_if ();

    hci_core_rr_arbiter_2x1 #(
        .DW              (32),
        .AW              (32),
        .UW              (1),
        .MAX_OUTSTANDING (4),
        .WRITE_RESP      (1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .err_o   (err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs shortly after the rising edge and let them settle
    task automatic applyStimulus(input logic s0r, input logic s0w, input logic [31:0] s0a,
                                 input logic s1r, input logic s1w, input logic [31:0] s1a,
                                 input logic mg, input logic mrv);
        s0_if.req    = s0r;
        s0_if.we_n   = s0w;
        s0_if.add    = s0a;
        s1_if.req    = s1r;
        s1_if.we_n   = s1w;
        s1_if.add    = s1a;
        m_if.gnt     = mg;
        m_if.r_valid = mrv;
        #2;
    endtask

    // Compare one observed value with its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        clear          = 1'b0;
        s0_if.be       = 4'hF;
        s1_if.be       = 4'h3;
        s0_if.data     = 32'hD000_00A0;
        s1_if.data     = 32'hD000_00B1;
        s0_if.user     = 1'b0;
        s1_if.user     = 1'b1;
        m_if.r_data    = 32'h0;
        m_if.r_user    = 1'b0;

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_s0_gnt", s0_if.gnt, 1'b1);
        checkOutput("rst_s1_gnt", s1_if.gnt, 1'b0);
        checkOutput("rst_s0_rvalid", s0_if.r_valid, 1'b0);
        checkOutput("rst_s1_rvalid", s1_if.r_valid, 1'b0);
        tick();
        rst_n = 1'b1;

        $display("[TB] single read from s0");
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        checkOutput("t1_s0_gnt", s0_if.gnt, 1'b1);
        checkOutput("t1_s1_gnt", s1_if.gnt, 1'b0);
        checkOutput("t1_m_req", m_if.req, 1'b1);
        checkOutput("t1_m_add", m_if.add, 32'h10);
        checkOutput("t1_m_we_n", m_if.we_n, 1'b1);
        checkOutput("t1_m_be", m_if.be, 4'hF);
        tick();
        m_if.r_data = 32'hCAFE_0001;
        m_if.r_user = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("t1_s0_rvalid", s0_if.r_valid, 1'b1);
        checkOutput("t1_s1_rvalid", s1_if.r_valid, 1'b0);
        checkOutput("t1_s0_rdata", s0_if.r_data, 32'hCAFE_0001);
        checkOutput("t1_s1_rdata", s1_if.r_data, 32'hCAFE_0001);
        checkOutput("t1_s1_ruser", s1_if.r_user, 1'b1);
        tick();

        // Priority now sits with s1; clear puts it back on s0
        clear = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        clear = 1'b0;

        $display("[TB] alternating grants");
        for (int k = 0; k < 6; k++) begin
            m_if.r_data = 32'h1000 + k;
            applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, (k > 0));
            checkOutput($sformatf("t2_s0_gnt_%0d", k), s0_if.gnt, ((k % 2) == 0));
            checkOutput($sformatf("t2_s1_gnt_%0d", k), s1_if.gnt, ((k % 2) == 1));
            checkOutput($sformatf("t2_m_add_%0d", k), m_if.add,
                        ((k % 2) == 0) ? 32'h100 : 32'h200);
            checkOutput($sformatf("t2_m_data_%0d", k), m_if.data,
                        ((k % 2) == 0) ? 32'hD000_00A0 : 32'hD000_00B1);
            checkOutput($sformatf("t2_m_user_%0d", k), m_if.user, ((k % 2) == 1));
            if (k > 0) begin
                checkOutput($sformatf("t2_s0_rvalid_%0d", k), s0_if.r_valid, (((k - 1) % 2) == 0));
                checkOutput($sformatf("t2_s1_rvalid_%0d", k), s1_if.r_valid, (((k - 1) % 2) == 1));
            end
            tick();
        end
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("t2_last_s0_rvalid", s0_if.r_valid, 1'b0);
        checkOutput("t2_last_s1_rvalid", s1_if.r_valid, 1'b1);
        tick();

        $display("[TB] outstanding limit");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
            checkOutput($sformatf("t3_m_req_%0d", k), m_if.req, 1'b1);
            checkOutput($sformatf("t3_s0_gnt_%0d", k), s0_if.gnt, ((k % 2) == 0));
            tick();
        end
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        checkOutput("t3_full_m_req", m_if.req, 1'b0);
        checkOutput("t3_full_s0_gnt", s0_if.gnt, 1'b0);
        checkOutput("t3_full_s1_gnt", s1_if.gnt, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        checkOutput("t3_popfull_m_req", m_if.req, 1'b0);
        checkOutput("t3_popfull_s0_gnt", s0_if.gnt, 1'b0);
        checkOutput("t3_popfull_s0_rvalid", s0_if.r_valid, 1'b1);
        checkOutput("t3_popfull_s1_rvalid", s1_if.r_valid, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        checkOutput("t3_resume_m_req", m_if.req, 1'b1);
        checkOutput("t3_resume_s0_gnt", s0_if.gnt, 1'b1);
        checkOutput("t3_resume_s1_gnt", s1_if.gnt, 1'b0);
        tick();
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
            checkOutput($sformatf("t3_drain_s1_rvalid_%0d", j), s1_if.r_valid, ((j % 2) == 0));
            checkOutput($sformatf("t3_drain_s0_rvalid_%0d", j), s0_if.r_valid, ((j % 2) == 1));
            tick();
        end

        $display("[TB] untracked write");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0);
        checkOutput("t4_s1_gnt", s1_if.gnt, 1'b1);
        checkOutput("t4_m_we_n", m_if.we_n, 1'b0);
        checkOutput("t4_m_be", m_if.be, 4'h3);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        checkOutput("t4_s0_gnt", s0_if.gnt, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("t4_s0_rvalid", s0_if.r_valid, 1'b1);
        checkOutput("t4_s1_rvalid", s1_if.r_valid, 1'b0);
        tick();

        $display("[TB] stray response and clear");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("t5_s0_rvalid", s0_if.r_valid, 1'b0);
        checkOutput("t5_s1_rvalid", s1_if.r_valid, 1'b0);
        checkOutput("t5_err_before", err, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("t5_err_set", err, 1'b1);
        tick();
        checkOutput("t5_err_sticky", err, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'hA0, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
        checkOutput("t5_err_cleared", err, 1'b0);
        checkOutput("t5_prio_m_add", m_if.add, 32'hA0);
        checkOutput("t5_m_req", m_if.req, 1'b1);
        checkOutput("t5_s0_gnt_nogrant", s0_if.gnt, 1'b0);
        tick();

        $display("[TB] reset with transactions in flight");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("t6_s0_gnt_%0d", k), s0_if.gnt, 1'b1);
            tick();
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("t6_rst_s0_rvalid", s0_if.r_valid, 1'b0);
        checkOutput("t6_rst_s1_rvalid", s1_if.r_valid, 1'b0);
        checkOutput("t6_rst_err", err, 1'b0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkOutput("t6_late_s0_rvalid", s0_if.r_valid, 1'b0);
        checkOutput("t6_late_s1_rvalid", s1_if.r_valid, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 32'h700, 1'b1, 1'b0);
        checkOutput("t6_late_err", err, 1'b1);
        checkOutput("t6_first_s0_gnt", s0_if.gnt, 1'b1);
        checkOutput("t6_first_s1_gnt", s1_if.gnt, 1'b0);
        checkOutput("t6_first_m_add", m_if.add, 32'h600);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
